// File: rtl/fifo_sync_prog.sv
// fifo_sync_prog: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise data_out
// is registered with one cycle of latency after an accepted read.
module fifo_sync_prog #(
  parameter int FIFO_data_size = 8,
  parameter int FIFO_addr_size = 4,
  parameter int AFULL_THRESH   = 12,
  parameter int AEMPTY_THRESH  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_en,
  input  logic [FIFO_data_size-1:0] data_in,
  input  logic                      r_en,
  output logic [FIFO_data_size-1:0] data_out,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic [FIFO_addr_size:0]   count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clr_err
);

  localparam int DEPTH = 2 ** FIFO_addr_size;
  localparam int CW    = FIFO_addr_size + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  logic [FIFO_data_size-1:0] mem [DEPTH];
  logic [FIFO_addr_size-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]             count_nxt;
  logic                      wr_acc, rd_acc, wr_rej, rd_rej;

  // Accept/reject decisions use only registered flags, so no flag depends
  // combinationally on w_en/r_en. A full FIFO still takes a write when a
  // read frees a slot in the same cycle.
  always_comb begin
    wr_acc = w_en && (!full || r_en);
    rd_acc = r_en && !empty;
    wr_rej = w_en && full && !r_en;
    rd_rej = r_en && empty;
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage: not reset, written only on an accepted write.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  // Pointers, occupancy and flags; flags are derived from the next count so
  // they describe the state after this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == DEPTH_C);
      almost_empty <= (count_nxt <= AEMPTY_C);
      almost_full  <= (count_nxt >= AFULL_C);
    end
  end

  // Sticky error flags; a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_rej)       overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (rd_rej)       underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is visible whenever the FIFO holds data; forced to 0 while
  // empty so the output is clean out of reset.
  always_comb begin
    data_out = '0;
    if (!empty) data_out = mem[rd_ptr];
  end
`else
  // Registered read: update only on an accepted pop, hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        data_out <= '0;
    else if (rd_acc) data_out <= mem[rd_ptr];
  end
`endif

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Directed bench for fifo_sync_prog (default depth 16, thresholds 12/2).
module tb_fifo_sync_prog;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       w_en = 1'b0, r_en = 1'b0, clr_err = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] count;
  int         errors = 0;
  int         checks = 0;

  fifo_sync_prog dut (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(data_out), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    w_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 8'(8'h40 + i);
      tick();
    end
    w_en = 1'b0;
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    // Async assert between edges.
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin
      errors++; $display("FAIL reset_flags got=%b exp=1010", {empty, full, almost_empty, almost_full});
    end
    checks++;
    if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_out); end
    checks++;
    if ({overflow, underflow} !== 2'b00) begin
      errors++; $display("FAIL reset_err got=%b exp=00", {overflow, underflow});
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    w_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_in = 8'(i);
      tick();
      checks++;
      if (count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i + 1); end
      checks++;
      if (almost_full !== ((i + 1) >= 12)) begin errors++; $display("FAIL fill_afull i=%0d got=%b", i, almost_full); end
      checks++;
      if (full !== ((i + 1) == 16)) begin errors++; $display("FAIL fill_full i=%0d got=%b", i, full); end
      checks++;
      if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty i=%0d got=%b exp=0", i, empty); end
    end
    data_in = 8'hEE;
    tick();
    w_en = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got=%b exp=1", overflow); end
    checks++;
    if (count !== 5'd16) begin errors++; $display("FAIL overflow_count got=%0d exp=16", count); end
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL overflow_uflow got=%b exp=0", underflow); end
    tick();
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got=%b exp=1", overflow); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clr got=%b exp=0", overflow); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      r_en = 1'b1;
`ifdef FIFO_FWFT_EN
      checks++;
      if (data_out !== 8'(i)) begin errors++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, data_out, 8'(i)); end
      tick();
`else
      tick();
      checks++;
      if (data_out !== 8'(i)) begin errors++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, data_out, 8'(i)); end
`endif
      checks++;
      if (count !== 5'(15 - i)) begin errors++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, count, 15 - i); end
      checks++;
      if (almost_empty !== ((15 - i) <= 2)) begin errors++; $display("FAIL drain_aempty i=%0d got=%b", i, almost_empty); end
      checks++;
      if (empty !== ((15 - i) == 0)) begin errors++; $display("FAIL drain_empty i=%0d got=%b", i, empty); end
    end
    tick();
    r_en = 1'b0;
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_set got=%b exp=1", underflow); end
    checks++;
    if (count !== 5'd0) begin errors++; $display("FAIL underflow_count got=%0d exp=0", count); end
`ifndef FIFO_FWFT_EN
    checks++;
    if (data_out !== 8'd15) begin errors++; $display("FAIL underflow_hold got=%h exp=0f", data_out); end
`endif
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_back_to_back();
    w_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_in = 8'(100 + i);
      tick();
    end
    r_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      data_in = 8'(116 + k);
`ifdef FIFO_FWFT_EN
      checks++;
      if (data_out !== 8'(100 + k)) begin errors++; $display("FAIL b2b_data k=%0d got=%0d exp=%0d", k, data_out, 100 + k); end
      tick();
`else
      tick();
      checks++;
      if (data_out !== 8'(100 + k)) begin errors++; $display("FAIL b2b_data k=%0d got=%0d exp=%0d", k, data_out, 100 + k); end
`endif
      checks++;
      if (count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL b2b_count k=%0d got=%0d full=%b exp=16/1", k, count, full); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_oflow k=%0d got=%b exp=0", k, overflow); end
    end
    // Drain after pointer wrap: head continues at 120.
    w_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
`ifdef FIFO_FWFT_EN
      checks++;
      if (data_out !== 8'(120 + i)) begin errors++; $display("FAIL wrap_data i=%0d got=%0d exp=%0d", i, data_out, 120 + i); end
      tick();
`else
      tick();
      checks++;
      if (data_out !== 8'(120 + i)) begin errors++; $display("FAIL wrap_data i=%0d got=%0d exp=%0d", i, data_out, 120 + i); end
`endif
    end
    r_en = 1'b0;
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  task automatic test_empty_wr_rd();
    w_en = 1'b1; r_en = 1'b1; data_in = 8'h3C;
    tick();
    w_en = 1'b0; r_en = 1'b0;
    checks++;
    if (count !== 5'd1 || empty !== 1'b0) begin errors++; $display("FAIL ewr_count got=%0d empty=%b exp=1/0", count, empty); end
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL ewr_uflow got=%b exp=1", underflow); end
`ifndef FIFO_FWFT_EN
    checks++;
    if (data_out !== 8'd135) begin errors++; $display("FAIL ewr_hold got=%0d exp=135", data_out); end
`endif
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL clr_err got=%b exp=00", {overflow, underflow}); end
    r_en = 1'b1;
`ifdef FIFO_FWFT_EN
    checks++;
    if (data_out !== 8'h3C) begin errors++; $display("FAIL ewr_pop got=%h exp=3c", data_out); end
    tick();
`else
    tick();
    checks++;
    if (data_out !== 8'h3C) begin errors++; $display("FAIL ewr_pop got=%h exp=3c", data_out); end
`endif
    // Underflow coinciding with clr_err: error wins.
    clr_err = 1'b1;
    tick();
    r_en = 1'b0; clr_err = 1'b0;
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL clr_vs_err got=%b exp=1", underflow); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

`ifdef FIFO_FWFT_EN
  task automatic test_fwft();
    w_en = 1'b1; data_in = 8'hA5;
    tick();
    w_en = 1'b0;
    checks++;
    if (empty !== 1'b0 || data_out !== 8'hA5) begin errors++; $display("FAIL fwft_show got=%h empty=%b exp=a5/0", data_out, empty); end
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL fwft_pop empty=%b exp=1", empty); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_empty_wr_rd();
`ifdef FIFO_FWFT_EN
    test_fwft();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
